// File: rtl/dc_offset_remover.sv
// dc_offset_remover: windowed-mean DC offset estimate with saturating removal.
// Define OFFSET_ROUND_EN to round the offset to nearest instead of flooring.
module dc_offset_remover #(
    parameter int M        = 14,
    parameter int LOG2_WIN = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic signed [M-1:0] vin_raw,
    output logic signed [M-1:0] vout,
    output logic                vout_valid,
    output logic signed [M-1:0] offset,
    output logic                offset_valid,
    output logic                sat
);

`ifdef OFFSET_ROUND_EN
    localparam int AW = M + LOG2_WIN + 1;
`else
    localparam int AW = M + LOG2_WIN;
`endif

    localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;
    localparam logic [LOG2_WIN-1:0] CNT_ONE  = LOG2_WIN'(1);
    localparam logic signed [M-1:0] VMAX = {1'b0, {(M-1){1'b1}}};
    localparam logic signed [M-1:0] VMIN = {1'b1, {(M-1){1'b0}}};

    logic signed [AW-1:0]   acc;
    logic [LOG2_WIN-1:0]    cnt;
    logic signed [AW-1:0]   acc_sum;
    logic signed [AW-1:0]   acc_fin;
    logic signed [M-1:0]    offset_nxt;
    logic signed [M:0]      diff;
    logic                   ovf;
    logic signed [M-1:0]    vout_nxt;
    logic                   win_end;

    assign acc_sum = acc + {{(AW-M){vin_raw[M-1]}}, vin_raw};

`ifdef OFFSET_ROUND_EN
    localparam logic signed [AW-1:0] HALF = AW'(1) << (LOG2_WIN - 1);
    assign acc_fin = acc_sum + HALF;
`else
    assign acc_fin = acc_sum;
`endif

    // Window mean; the shifted value always fits back into M bits.
    assign offset_nxt = M'(acc_fin >>> LOG2_WIN);
    assign win_end    = (cnt == CNT_LAST);

    // One extra bit keeps the difference exact before clamping.
    assign diff     = {vin_raw[M-1], vin_raw} - {offset[M-1], offset};
    assign ovf      = diff[M] ^ diff[M-1];
    assign vout_nxt = ovf ? (diff[M] ? VMIN : VMAX) : diff[M-1:0];

    // Accumulate one window of samples and publish its mean at window end.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            cnt          <= '0;
            offset       <= '0;
            offset_valid <= 1'b0;
        end else if (sample_en) begin
            if (win_end) begin
                acc          <= '0;
                cnt          <= '0;
                offset       <= offset_nxt;
                offset_valid <= 1'b1;
            end else begin
                acc <= acc_sum;
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // Subtract the current offset and clamp, one cycle after each sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            vout       <= '0;
            vout_valid <= 1'b0;
            sat        <= 1'b0;
        end else begin
            vout_valid <= sample_en;
            if (sample_en) begin
                vout <= vout_nxt;
                sat  <= ovf;
            end else begin
                sat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dc_offset_remover.sv
// tb_dc_offset_remover: directed table, hand sequences and random vs model.
// Expected offsets follow OFFSET_ROUND_EN when the bench is built with it.
module tb_dc_offset_remover;

    localparam int M        = 14;
    localparam int LOG2_WIN = 2;
    localparam int W        = 1 << LOG2_WIN;
    localparam int VMAX     = (1 << (M - 1)) - 1;
    localparam int VMIN     = -(1 << (M - 1));

`ifdef OFFSET_ROUND_EN
    localparam int FR_OFF = -1;
`else
    localparam int FR_OFF = -2;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                sample_en = 1'b0;
    logic signed [M-1:0] vin_raw = '0;
    logic signed [M-1:0] vout;
    logic                vout_valid;
    logic signed [M-1:0] offset;
    logic                offset_valid;
    logic                sat;

    int n_checks = 0;
    int n_fail   = 0;

    dc_offset_remover #(
        .M        (M),
        .LOG2_WIN (LOG2_WIN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .vin_raw      (vin_raw),
        .vout         (vout),
        .vout_valid   (vout_valid),
        .offset       (offset),
        .offset_valid (offset_valid),
        .sat          (sat)
    );

    always #5 clk = ~clk;

    // Reference model: window of raw samples, mean by integer division.
    int q[$];
    int m_off;
    bit m_ov;
    int m_vout;
    bit m_vv;
    bit m_sat;

    function automatic int fdiv(input int n, input int d);
        int r;
        r = n / d;
        if ((n % d != 0) && (n < 0)) r = r - 1;
        return r;
    endfunction

    function automatic int win_mean(input int s);
`ifdef OFFSET_ROUND_EN
        return fdiv(s + W / 2, W);
`else
        return fdiv(s, W);
`endif
    endfunction

    task automatic model_step(input bit r, input bit en, input int x);
        int d;
        int s;
        if (r) begin
            q.delete();
            m_off  = 0;
            m_ov   = 0;
            m_vout = 0;
            m_vv   = 0;
            m_sat  = 0;
        end else begin
            m_vv  = en;
            m_sat = 0;
            if (en) begin
                d = x - m_off;
                if (d > VMAX) begin
                    m_vout = VMAX;
                    m_sat  = 1;
                end else if (d < VMIN) begin
                    m_vout = VMIN;
                    m_sat  = 1;
                end else begin
                    m_vout = d;
                end
                q.push_back(x);
                if (q.size() == W) begin
                    s = 0;
                    foreach (q[i]) s = s + q[i];
                    m_off = win_mean(s);
                    m_ov  = 1;
                    q.delete();
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit en, input int x);
        rst       = r;
        sample_en = en;
        vin_raw   = M'(x);
        @(posedge clk);
        #1;
        model_step(r, en, x);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ev, input int evv,
                           input int eo, input int eov, input int es);
        chk({tag, ".vout"}, int'(vout), ev);
        chk({tag, ".vout_valid"}, int'(vout_valid), evv);
        chk({tag, ".offset"}, int'(offset), eo);
        chk({tag, ".offset_valid"}, int'(offset_valid), eov);
        chk({tag, ".sat"}, int'(sat), es);
    endtask

    typedef struct {
        string nm;
        bit    r;
        bit    en;
        int    vin;
        int    ev;
        int    evv;
        int    eo;
        int    eov;
        int    es;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int bias;
        int amp;
        int v;
        bit full;

        // Directed vectors: inputs then outputs seen just after the edge.
        tbl.push_back('{"rst0",  1, 1,   500,    0, 0,     0, 0, 0});
        tbl.push_back('{"rst1",  1, 1,   500,    0, 0,     0, 0, 0});
        tbl.push_back('{"rel",   0, 0,     0,    0, 0,     0, 0, 0});
        tbl.push_back('{"dc1",   0, 1,   100,  100, 1,     0, 0, 0});
        tbl.push_back('{"dc2",   0, 1,   100,  100, 1,     0, 0, 0});
        tbl.push_back('{"dc3",   0, 1,   100,  100, 1,     0, 0, 0});
        tbl.push_back('{"dc4",   0, 1,   100,  100, 1,   100, 1, 0});
        tbl.push_back('{"dc5",   0, 1,   100,    0, 1,   100, 1, 0});
        tbl.push_back('{"dcid",  0, 0,     0,    0, 0,   100, 1, 0});
        tbl.push_back('{"frr",   1, 0,     0,    0, 0,     0, 0, 0});
        tbl.push_back('{"fr1",   0, 1,    -1,   -1, 1,     0, 0, 0});
        tbl.push_back('{"fr2",   0, 1,    -1,   -1, 1,     0, 0, 0});
        tbl.push_back('{"fr3",   0, 1,    -1,   -1, 1,     0, 0, 0});
        tbl.push_back('{"fr4",   0, 1,    -2,   -2, 1, FR_OFF, 1, 0});
        tbl.push_back('{"satr",  1, 0,     0,    0, 0,     0, 0, 0});
        tbl.push_back('{"sat1",  0, 1, -8000, -8000, 1,    0, 0, 0});
        tbl.push_back('{"sat2",  0, 1, -8000, -8000, 1,    0, 0, 0});
        tbl.push_back('{"sat3",  0, 1, -8000, -8000, 1,    0, 0, 0});
        tbl.push_back('{"sat4",  0, 1, -8000, -8000, 1, -8000, 1, 0});
        tbl.push_back('{"sathi", 0, 1,  8191, 8191, 1, -8000, 1, 1});
        tbl.push_back('{"sat0",  0, 1,     0, 8000, 1, -8000, 1, 0});
        tbl.push_back('{"satid", 0, 0,     0, 8000, 0, -8000, 1, 0});

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].en, tbl[i].vin);
            chk_all(tbl[i].nm, tbl[i].ev, tbl[i].evv,
                    tbl[i].eo, tbl[i].eov, tbl[i].es);
        end

        // Gapped enable: valid pulses once per sample, counter only on enable.
        step(1, 0, 0);
        for (int i = 0; i < W; i++) begin
            step(0, 1, 40);
            chk_all($sformatf("gap_s%0d", i), 40, 1,
                    (i == W - 1) ? 40 : 0, (i == W - 1) ? 1 : 0, 0);
            for (int k = 0; k < 3; k++) begin
                step(0, 0, 0);
                chk_all($sformatf("gap_i%0d_%0d", i, k), 40, 0,
                        (i == W - 1) ? 40 : 0, (i == W - 1) ? 1 : 0, 0);
            end
        end

        // Reset mid-window discards the partial sum.
        step(1, 0, 0);
        step(0, 1, 10);
        chk_all("mid_a", 10, 1, 0, 0, 0);
        step(0, 1, 10);
        chk_all("mid_b", 10, 1, 0, 0, 0);
        step(1, 0, 0);
        chk_all("mid_rst", 0, 0, 0, 0, 0);
        for (int i = 0; i < W; i++) begin
            step(0, 1, 20);
            chk_all($sformatf("mid_%0d", i), 20, 1,
                    (i == W - 1) ? 20 : 0, (i == W - 1) ? 1 : 0, 0);
        end
        step(0, 1, 20);
        chk_all("mid_post", 0, 1, 20, 1, 0);

        // Random segments of biased noise, gaps and occasional resets.
        step(1, 0, 0);
        bias = 0;
        amp  = 0;
        full = 0;
        for (int n = 0; n < 800; n++) begin
            if (n % 40 == 0) begin
                bias = int'($urandom_range(0, 16383)) - 8192;
                amp  = int'($urandom_range(0, 300));
                full = ($urandom_range(0, 7) == 0);
            end
            if (full) begin
                v = int'($urandom_range(0, 16383)) - 8192;
            end else begin
                v = bias + int'($urandom_range(0, 2 * amp)) - amp;
                if (v > VMAX) v = VMAX;
                if (v < VMIN) v = VMIN;
            end
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), v);
            chk_all($sformatf("rnd%0d", n), m_vout, m_vv, m_off, m_ov, m_sat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
